// File: rtl/btn_evt_pkg.sv
// Shared types and the round-robin search used by the button event scheduler.
package btn_evt_pkg;

    localparam int MAX_CH   = 16;
    localparam int MAX_CH_W = 4;

    typedef struct packed {
        logic [MAX_CH_W-1:0] ch;
        logic                rise;
    } evt_t;

    typedef struct packed {
        logic                found;
        logic [MAX_CH_W-1:0] idx;
    } grant_t;

    // First set request after 'last', wrapping modulo n. The loop runs from the
    // far end down so the nearest candidate overwrites any farther one.
    function automatic grant_t rr_pick(input logic [MAX_CH-1:0]   req,
                                       input logic [MAX_CH_W-1:0] last,
                                       input int                  n);
        grant_t g;
        int     idx;
        g = '0;
        for (int i = MAX_CH; i >= 1; i--) begin
            if (i <= n) begin
                idx = (int'(last) + i) % n;
                if (req[idx[MAX_CH_W-1:0]]) begin
                    g.found = 1'b1;
                    g.idx   = idx[MAX_CH_W-1:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/debounce_lane.sv
// One button channel: 2-flop synchronizer, tick-driven stability counter and
// debounced level; flags the tick on which a new level is accepted.
module debounce_lane #(
    parameter int STABLE_TICKS = 16,
    parameter int TCNT_W       = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic in_i,
    output logic level_o,
    output logic acc_o,
    output logic acc_val_o
);

    logic              meta_q, sync_q, level_q;
    logic [TCNT_W-1:0] cnt_q;
    logic              disagree, at_max;

    assign disagree  = (sync_q != level_q);
    assign at_max    = (cnt_q == TCNT_W'(STABLE_TICKS - 1));
    assign acc_o     = tick_i && disagree && at_max;
    assign acc_val_o = sync_q;
    assign level_o   = level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= in_i;
            sync_q <= meta_q;
            if (tick_i) begin
                // Any agreeing sample restarts the run, which is what rejects glitches.
                if (!disagree) begin
                    cnt_q <= '0;
                end else if (at_max) begin
                    level_q <= sync_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + TCNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/btn_event_scheduler.sv
// Debounces N_CH buttons on a shared tick and serializes their edges into a
// single press/release event stream through a round-robin valid/ready port.
module btn_event_scheduler
    import btn_evt_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int PRESCALE     = 1000,
    parameter int STABLE_TICKS = 16,
    parameter int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int TCNT_W       = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in_i,
    output logic [N_CH-1:0] level_o,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [CH_W-1:0] evt_ch_o,
    output logic            evt_rise_o,
    output logic [N_CH-1:0] overrun_o,
    input  logic [N_CH-1:0] clr_overrun_i
);

    localparam int PS_W = $clog2(PRESCALE);

    logic [PS_W-1:0] ps_q;
    logic            tick;

    assign tick = (ps_q == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ps_q <= '0;
        else     ps_q <= tick ? '0 : ps_q + PS_W'(1);
    end

    logic [N_CH-1:0] acc, acc_val;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        debounce_lane #(
            .STABLE_TICKS(STABLE_TICKS),
            .TCNT_W      (TCNT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .tick_i   (tick),
            .in_i     (in_i[g]),
            .level_o  (level_o[g]),
            .acc_o    (acc[g]),
            .acc_val_o(acc_val[g])
        );
    end

    logic [N_CH-1:0] pend_q, pend_d, pend_dir_q, pend_dir_d, ovr_q, ovr_d;
    logic [CH_W-1:0] last_q, gnt_ch;
    logic [N_CH-1:0] gnt_oh;
    logic            evt_valid_q, load, fire;
    evt_t            evt_q;
    grant_t          gnt;

    assign gnt    = rr_pick(MAX_CH'(pend_q), MAX_CH_W'(last_q), N_CH);
    assign gnt_ch = gnt.idx[CH_W-1:0];
    assign load   = !evt_valid_q || evt_ready_i;
    assign fire   = load && gnt.found;
    assign gnt_oh = fire ? (N_CH'(1) << gnt_ch) : '0;

    // A new edge always lands in pend; it only counts as overrun when the old
    // edge is not leaving through the arbiter in the same cycle.
    always_comb begin
        pend_d     = (pend_q & ~gnt_oh) | acc;
        pend_dir_d = (pend_dir_q & ~acc) | (acc_val & acc);
        ovr_d      = (ovr_q & ~clr_overrun_i) | (acc & pend_q & ~gnt_oh);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            pend_dir_q <= '0;
            ovr_q      <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
            ovr_q      <= ovr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid_q <= 1'b0;
            evt_q       <= '0;
            last_q      <= CH_W'(N_CH - 1);
        end else if (load) begin
            evt_valid_q <= gnt.found;
            if (gnt.found) begin
                evt_q.ch   <= gnt.idx;
                evt_q.rise <= pend_dir_q[gnt_ch];
                last_q     <= gnt_ch;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{gnt.idx, evt_q.ch};

    assign evt_valid_o = evt_valid_q;
    assign evt_ch_o    = evt_q.ch[CH_W-1:0];
    assign evt_rise_o  = evt_q.rise;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed bench for btn_event_scheduler with PRESCALE=4, STABLE_TICKS=3, N_CH=4.
module tb_btn_event_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_v = '0;
    logic [3:0] clr = '0;
    logic       ready = 1'b0;
    logic [3:0] level, ovr;
    logic       valid, rise;
    logic [1:0] ch;

    int n_chk  = 0;
    int n_fail = 0;
    int pc;

    always #5 clk = ~clk;

    // Bench-side tick phase, used only to align stimulus to sample ticks.
    always @(posedge clk or posedge rst) begin
        if (rst) pc <= 0;
        else     pc <= (pc == 3) ? 0 : pc + 1;
    end

    btn_event_scheduler #(
        .N_CH        (4),
        .PRESCALE    (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_i         (in_v),
        .level_o      (level),
        .evt_valid_o  (valid),
        .evt_ready_i  (ready),
        .evt_ch_o     (ch),
        .evt_rise_o   (rise),
        .overrun_o    (ovr),
        .clr_overrun_i(clr)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge right after the next tick edge.
    task automatic wait_tick();
        do @(negedge clk); while (pc != 0);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_v = '0; clr = '0; ready = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if ({level, valid, ch, rise, ovr} !== 12'h000) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 000", {level, valid, ch, rise, ovr});
        end
        n_chk++;
        cyc(6);
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_valid: got %b want 0", valid);
        end
        n_chk++;
    endtask

    task automatic test_clean_press();
        do_reset();
        wait_tick();
        in_v = 4'b0001;
        wait_ticks(2);
        if (level !== 4'b0000) begin
            n_fail++; $display("FAIL press_early_level: got %b want 0000", level);
        end
        n_chk++;
        wait_tick();
        if (level !== 4'b0001) begin
            n_fail++; $display("FAIL press_level: got %b want 0001", level);
        end
        n_chk++;
        cyc(1);
        if ({valid, ch, rise} !== 4'b1_00_1) begin
            n_fail++; $display("FAIL press_event: got v%b ch%0d r%b want v1 ch0 r1", valid, ch, rise);
        end
        n_chk++;
        cyc(2);
        if ({valid, ch, rise} !== 4'b1_00_1) begin
            n_fail++; $display("FAIL press_hold: got v%b ch%0d r%b want v1 ch0 r1", valid, ch, rise);
        end
        n_chk++;
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL press_drop: got %b want 0", valid);
        end
        n_chk++;
    endtask

    task automatic test_glitch();
        int cnt;
        do_reset();
        ready = 1'b1;
        wait_tick();
        in_v = 4'b0010;
        wait_ticks(2);
        in_v = 4'b0000;
        wait_tick();
        in_v = 4'b0010;
        wait_ticks(2);
        if (level !== 4'b0000) begin
            n_fail++; $display("FAIL glitch_restart: got %b want 0000", level);
        end
        n_chk++;
        wait_tick();
        if (level !== 4'b0010) begin
            n_fail++; $display("FAIL glitch_level: got %b want 0010", level);
        end
        n_chk++;
        cnt = 0;
        repeat (4) begin
            cyc(1);
            if (valid) begin
                cnt++;
                if ({ch, rise} !== 3'b01_1) begin
                    n_fail++; $display("FAIL glitch_event: got ch%0d r%b want ch1 r1", ch, rise);
                end
                n_chk++;
            end
        end
        if (cnt != 1) begin
            n_fail++; $display("FAIL glitch_count: got %0d want 1", cnt);
        end
        n_chk++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        ready = 1'b1;
        wait_tick();
        in_v = 4'b1111;
        wait_ticks(3);
        if (level !== 4'b1111) begin
            n_fail++; $display("FAIL simul_level: got %b want 1111", level);
        end
        n_chk++;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            if ({valid, ch, rise} !== {1'b1, 2'(k), 1'b1}) begin
                n_fail++; $display("FAIL simul_event%0d: got v%b ch%0d r%b want v1 ch%0d r1", k, valid, ch, rise, k);
            end
            n_chk++;
        end
        cyc(1);
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL simul_drain: got %b want 0", valid);
        end
        n_chk++;
    endtask

    task automatic test_round_robin();
        do_reset();
        ready = 1'b1;
        wait_tick();
        in_v = 4'b0100;
        wait_ticks(3);
        cyc(1);
        if ({valid, ch} !== 3'b1_10) begin
            n_fail++; $display("FAIL rr_first: got v%b ch%0d want v1 ch2", valid, ch);
        end
        n_chk++;
        wait_tick();
        in_v = 4'b1101;
        wait_ticks(3);
        cyc(1);
        if ({valid, ch} !== 3'b1_11) begin
            n_fail++; $display("FAIL rr_ch3_first: got v%b ch%0d want v1 ch3", valid, ch);
        end
        n_chk++;
        cyc(1);
        if ({valid, ch} !== 3'b1_00) begin
            n_fail++; $display("FAIL rr_ch0_second: got v%b ch%0d want v1 ch0", valid, ch);
        end
        n_chk++;
        cyc(1);
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_drain: got %b want 0", valid);
        end
        n_chk++;
    endtask

    task automatic test_overrun();
        int cnt;
        do_reset();
        wait_tick();
        in_v = 4'b0001;
        wait_ticks(3);
        cyc(1);
        if ({valid, ch, rise} !== 4'b1_00_1) begin
            n_fail++; $display("FAIL ovr_block_evt: got v%b ch%0d r%b want v1 ch0 r1", valid, ch, rise);
        end
        n_chk++;
        wait_tick();
        in_v = 4'b0101;
        wait_ticks(3);
        if (ovr !== 4'b0000) begin
            n_fail++; $display("FAIL ovr_single_edge: got %b want 0000", ovr);
        end
        n_chk++;
        wait_tick();
        in_v = 4'b0001;
        wait_ticks(3);
        if (ovr !== 4'b0100) begin
            n_fail++; $display("FAIL ovr_set: got %b want 0100", ovr);
        end
        n_chk++;
        if ({valid, ch} !== 3'b1_00) begin
            n_fail++; $display("FAIL ovr_held: got v%b ch%0d want v1 ch0", valid, ch);
        end
        n_chk++;
        ready = 1'b1;
        cyc(1);
        if ({valid, ch, rise} !== 4'b1_10_0) begin
            n_fail++; $display("FAIL ovr_evt: got v%b ch%0d r%b want v1 ch2 r0", valid, ch, rise);
        end
        n_chk++;
        cnt = 0;
        repeat (6) begin
            cyc(1);
            if (valid) cnt++;
        end
        if (cnt != 0) begin
            n_fail++; $display("FAIL ovr_single_delivery: got %0d extra events want 0", cnt);
        end
        n_chk++;
        if (ovr !== 4'b0100) begin
            n_fail++; $display("FAIL ovr_sticky: got %b want 0100", ovr);
        end
        n_chk++;
        clr = 4'b0100;
        cyc(1);
        clr = 4'b0000;
        if (ovr !== 4'b0000) begin
            n_fail++; $display("FAIL ovr_clear: got %b want 0000", ovr);
        end
        n_chk++;
    endtask

    task automatic test_reset_mid();
        int cnt;
        do_reset();
        wait_tick();
        in_v = 4'b0011;
        wait_ticks(3);
        cyc(1);
        if ({valid, ch} !== 3'b1_00) begin
            n_fail++; $display("FAIL rmid_pre: got v%b ch%0d want v1 ch0", valid, ch);
        end
        n_chk++;
        #1 rst = 1'b1;
        #1;
        if ({level, valid, ch, rise, ovr} !== 12'h000) begin
            n_fail++; $display("FAIL rmid_async: got %h want 000", {level, valid, ch, rise, ovr});
        end
        n_chk++;
        in_v = 4'b0000;
        cyc(1);
        rst = 1'b0;
        ready = 1'b1;
        cnt = 0;
        repeat (20) begin
            cyc(1);
            if (valid) cnt++;
        end
        if (cnt != 0) begin
            n_fail++; $display("FAIL rmid_stale: got %0d events want 0", cnt);
        end
        n_chk++;
        wait_tick();
        in_v = 4'b1001;
        wait_ticks(3);
        cyc(1);
        if ({valid, ch} !== 3'b1_00) begin
            n_fail++; $display("FAIL rmid_first_grant: got v%b ch%0d want v1 ch0", valid, ch);
        end
        n_chk++;
        cyc(1);
        if ({valid, ch} !== 3'b1_11) begin
            n_fail++; $display("FAIL rmid_second_grant: got v%b ch%0d want v1 ch3", valid, ch);
        end
        n_chk++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_simultaneous();
        test_round_robin();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_event_scheduler.md
Name: btn_event_scheduler

Overview:
- Multi-channel button front end: samples N_CH raw inputs and debounces each channel with one shared prescaler tick.
- Debounced edges are serialized into a single press/release event stream through a round-robin arbiter with a valid/ready handshake.
- Sits between board pins and the control/UI logic, which consumes one event per handshake instead of polling N levels.

Parameters:
- N_CH, 4, number of button channels (1..16).
- PRESCALE, 1000, clk cycles per sample tick (>=2).
- STABLE_TICKS, 16, consecutive disagreeing ticks needed to accept a new level (>=1).
- CH_W, $clog2(N_CH) (min 1), width of the channel index (derived).
- TCNT_W, $clog2(STABLE_TICKS) (min 1), width of the per-channel stability counter (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in  in  N_CH  raw asynchronous button inputs.
- level  out  N_CH  debounced level per channel.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_ch  out  CH_W  channel of the current event.
- evt_rise  out  1  1 = press (0->1), 0 = release (1->0).
- overrun  out  N_CH  sticky flag: an edge was replaced before it was delivered.
- clr_overrun  in  N_CH  per-bit clear of overrun; 1-cycle pulse.

Behaviour:
- Reset, asynchronous: sync flops, level, the stability counters, pend, pend_dir, overrun, evt_valid, evt_ch, evt_rise and the prescaler all clear to 0. last_grant resets to N_CH-1, so ch0 has first priority.
- Synchronizer: 2 flops per channel. sync = second flop.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 for one cycle when count==PRESCALE-1.
- Per channel, evaluated on tick only:
  - sync==level: counter <= 0.
  - sync!=level and counter<STABLE_TICKS-1: counter increments.
  - sync!=level and counter==STABLE_TICKS-1: level <= sync, counter <= 0, pend <= 1, pend_dir <= sync.
  - Net effect: level changes on the STABLE_TICKS-th consecutive disagreeing tick.
  - Any agreeing tick restarts the count (glitch rejection).
- Latency from a clean input change to level: 2 cycles + up to STABLE_TICKS*PRESCALE cycles.
- Overrun: if a new edge is accepted while pend is already 1 and that channel is not granted this cycle, then overrun <= 1 and pend_dir <= newest value. Only one event per channel is ever queued.
- Output register load condition: load = !evt_valid || evt_ready.
- On load with any pend bit set:
  - Grant the first pending channel searching last_grant+1 upward, with wrap.
  - evt_ch <= grant, evt_rise <= pend_dir[grant], evt_valid <= 1, last_grant <= grant, pend[grant] <= 0.
- On load with no pend bit set: evt_valid <= 0.
- Payload is held stable while evt_valid && !evt_ready.
- Back-to-back events are allowed: one per cycle while evt_ready=1.
- Same cycle, same channel, grant and new edge:
  - The granted event carries the old pend_dir.
  - pend stays 1 with the new dir.
  - No overrun.
- clr_overrun and a new overrun set on the same bit in the same cycle: set wins.
- Events are generated only on ticks. Arbitration runs every cycle.

Decomposition:
- Package btn_evt_pkg holds:
  - evt_t typedef (ch, rise).
  - Helper function for the round-robin next-grant search.
- Sub-module debounce_lane, one instance per channel, contains:
  - Synchronizer and stability counter.
  - level register.
  - 1-cycle accept pulse plus new value.
- Top level holds the prescaler, pend/pend_dir/overrun arrays, arbiter and output register.

Test Plan (PRESCALE=4, STABLE_TICKS=3, N_CH=4):
- Clean press: in=4'b0001 held -> level[0] rises within 2+12+4 cycles of the change. Then exactly one event: ch=0, rise=1. evt_valid drops after the handshake.
- Glitch: in[1] high for 2 ticks, low for 1 tick, then high for 3 ticks -> no level change until the 3rd consecutive tick. Exactly one event: ch=1, rise=1.
- Simultaneous: in 0000->1111 with evt_ready=1 -> level=1111 on the same tick. Events appear on consecutive cycles in order ch0,1,2,3, all with rise=1.
- Round-robin fairness: last grant was ch2, then ch0 and ch3 become pending together -> ch3 is granted before ch0.
- Backpressure/overrun: evt_ready=0, then ch2 press and release are both accepted -> overrun[2]=1. With evt_ready=1, exactly one ch2 event is delivered, with rise=0. A clr_overrun[2] pulse then clears overrun[2].
- Reset mid-operation: assert rst while evt_valid=1 and ch1 pend=1 -> all outputs are 0 immediately (async). After release, no stale events appear and the first grant goes to ch0.
